// File: rtl/pipe_reg_skid_pkg.sv
// Shared definitions for the pipe_reg_skid elastic pipeline register.
// Stage state encodings: bit 0 means M holds a beat, bit 1 means S holds a beat.
package pipe_reg_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_reg_skid_stage.sv
// One skid-buffer stage: main reg M plus skid reg S. Ready is a registered state bit.
// Optional flush input exists only when PIPE_REG_FLUSH_EN is defined.
module skid_stage
  import pipe_reg_skid_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             srst,
`ifdef PIPE_REG_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     state_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] s_reg;
  logic             push;
  logic             pop;
  logic             flush_w;

`ifdef PIPE_REG_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // The encoding makes ready and valid plain register bits, so ready never
  // depends combinationally on the downstream out_ready.
  assign in_ready  = ~state_reg[1];
  assign out_valid = state_reg[0];
  assign out_data  = m_reg;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_EMPTY;
      m_reg     <= '0;
      s_reg     <= '0;
    end else if (flush_w) begin
      state_reg <= ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (push) begin
            m_reg     <= in_data;
            state_reg <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            m_reg <= in_data;
          end else if (push) begin
            s_reg     <= in_data;
            state_reg <= ST_FULL;
          end else if (pop) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            m_reg     <= s_reg;
            state_reg <= ST_ONE;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register: DEPTH cascaded skid stages with valid/ready on both sides.
// Define PIPE_REG_FLUSH_EN to add the FLUSH port that empties every stage.
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             C,
  input  logic             R,
`ifdef PIPE_REG_FLUSH_EN
  input  logic             FLUSH,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH:0]   v_chain;
  logic [DEPTH:0]   r_chain;
  logic [WIDTH-1:0] d_chain [DEPTH+1];

  assign v_chain[0]     = in_valid;
  assign d_chain[0]     = in_data;
  assign r_chain[DEPTH] = out_ready;
  assign out_valid      = v_chain[DEPTH];
  assign out_data       = d_chain[DEPTH];

  // Stage 0 ignores pushes while clearing, so masking only the visible ready
  // keeps upstream from believing a beat was taken.
`ifdef PIPE_REG_FLUSH_EN
  assign in_ready = r_chain[0] & ~R & ~FLUSH;
`else
  assign in_ready = r_chain[0] & ~R;
`endif

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      skid_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (C),
        .srst     (R),
`ifdef PIPE_REG_FLUSH_EN
        .flush    (FLUSH),
`endif
        .in_valid (v_chain[gi]),
        .in_ready (r_chain[gi]),
        .in_data  (d_chain[gi]),
        .out_valid(v_chain[gi+1]),
        .out_ready(r_chain[gi+1]),
        .out_data (d_chain[gi+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed and random checks for pipe_reg_skid (WIDTH=34, DEPTH=2).
// Inputs change and outputs are sampled 1ns after the falling edge.
module tb_pipe_reg_skid;
  localparam int W = 34;
  localparam int D = 2;
  localparam int NRAND = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv;
  logic         ir;
  logic [W-1:0] id;
  logic         ov;
  logic         ordy;
  logic [W-1:0] od;
`ifdef PIPE_REG_FLUSH_EN
  logic         flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] q [$];

  always #5 clk = ~clk;

  pipe_reg_skid #(.WIDTH(W), .DEPTH(D)) dut (
    .C        (clk),
    .R        (rst),
`ifdef PIPE_REG_FLUSH_EN
    .FLUSH    (flush),
`endif
    .in_valid (iv),
    .in_ready (ir),
    .in_data  (id),
    .out_valid(ov),
    .out_ready(ordy),
    .out_data (od)
  );

  typedef struct {
    logic         r;
    logic         v;
    logic [W-1:0] d;
    logic         o;
    logic         e_ir;
    logic         e_ov;
    logic         chk_d;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic o);
    rst = r; iv = v; id = d; ordy = o;
`ifdef PIPE_REG_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Scoreboard pop for a beat leaving the block at the coming edge.
  task automatic deliver(input string name);
    if (q.size() == 0) begin
      check({name, "_unexpected"}, od, 'x);
    end else begin
      check(name, od, q.pop_front());
    end
  endtask

  task automatic sv(input int i, input logic r, input logic v, input int d, input logic o,
                    input logic e_ir, input logic e_ov, input logic chk_d, input int e_od);
    tbl[i] = '{r, v, W'(d), o, e_ir, e_ov, chk_d, W'(e_od)};
  endtask

  // Waits a bounded number of cycles for a beat, then expects exactly it and nothing after.
  task automatic wait_single(input string name, input logic [W-1:0] exp);
    for (int i = 0; i < 10; i++) begin
      if (ov) break;
      next(); drive(0, 0, '0, 1);
    end
    check({name, "_valid"}, W'(ov), W'(1));
    check(name, od, exp);
    next(); drive(0, 0, '0, 1);
    check({name, "_only_one"}, W'(ov), W'(0));
  endtask

  initial begin
    int acc, got, cyc, first_acc, first_ov;
    logic pend, pov, por;
    logic [W-1:0] pd, pod;

    // reset, stall to capacity, release and drain
    sv(0,  1, 1, 1, 0, 0, 0, 1, 0);
    sv(1,  1, 1, 1, 1, 0, 0, 1, 0);
    sv(2,  0, 0, 0, 1, 1, 0, 1, 0);
    sv(3,  0, 0, 0, 1, 1, 0, 1, 0);
    sv(4,  0, 1, 0, 0, 1, 0, 0, 0);
    sv(5,  0, 1, 1, 0, 1, 0, 0, 0);
    sv(6,  0, 1, 2, 0, 1, 1, 1, 0);
    sv(7,  0, 1, 3, 0, 1, 1, 1, 0);
    sv(8,  0, 1, 4, 0, 0, 1, 1, 0);
    sv(9,  0, 1, 4, 0, 0, 1, 1, 0);
    sv(10, 0, 1, 4, 1, 0, 1, 1, 0);
    sv(11, 0, 1, 4, 1, 0, 1, 1, 1);
    sv(12, 0, 1, 4, 1, 1, 1, 1, 2);
    sv(13, 0, 1, 5, 1, 1, 1, 1, 3);
    sv(14, 0, 0, 0, 1, 1, 1, 1, 4);
    sv(15, 0, 0, 0, 1, 1, 1, 1, 5);
    sv(16, 0, 0, 0, 1, 1, 0, 0, 0);

    drive(1, 1, W'(1), 0);
    @(posedge clk);
    next();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].o);
      check($sformatf("vec%0d_in_ready", i), W'(ir), W'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), W'(ov), W'(tbl[i].e_ov));
      if (tbl[i].chk_d) check($sformatf("vec%0d_out_data", i), od, tbl[i].e_od);
      next();
    end

    // back-to-back streaming with no stalls
    q.delete();
    acc = 0; got = 0; cyc = 0; first_acc = -1; first_ov = -1;
    while (got < 100 && cyc < 400) begin
      drive(0, acc < 100, W'(acc), 1);
      if (ov && first_ov < 0) first_ov = cyc;
      if (iv) check("stream_in_ready", W'(ir), W'(1));
      if (iv && ir) begin
        if (first_acc < 0) first_acc = cyc;
        q.push_back(id);
        acc++;
      end
      if (ov && ordy) begin
        deliver("stream_data");
        got++;
      end
      next();
      cyc++;
    end
    check("stream_count", W'(got), W'(100));
    check("stream_latency", W'(first_ov - first_acc), W'(D));

    // random valid and back-pressure
    acc = 0; got = 0; cyc = 0; pend = 0; pov = 0; por = 1; pd = '0; pod = '0;
    while (got < NRAND && cyc < 40000) begin
      if (!pend && acc < NRAND && $urandom_range(1) == 1) begin
        pend = 1'b1;
        pd = W'({$urandom(), $urandom()});
      end
      drive(0, pend, pend ? pd : '0, $urandom_range(1) == 1);
      if (pov && !por) begin
        check("hold_valid", W'(ov), W'(1));
        check("hold_data", od, pod);
      end
      if (iv && ir) begin
        q.push_back(id);
        acc++;
        pend = 1'b0;
      end
      if (ov && ordy) begin
        deliver("rand_data");
        got++;
      end
      pov = ov; pod = od; por = ordy;
      next();
      cyc++;
    end
    check("rand_count", W'(got), W'(NRAND));

    // mid-stream reset drops held beats
    drive(0, 0, '0, 1);
    next();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, W'(34'h100 + k), 0);
      check("rst_fill_ready", W'(ir), W'(1));
      next();
    end
    drive(1, 1, W'(34'h1FF), 0);
    check("rst_pulse_in_ready", W'(ir), W'(0));
    check("rst_held_valid", W'(ov), W'(1));
    next();
    drive(0, 0, '0, 1);
    check("rst_after_out_valid", W'(ov), W'(0));
    check("rst_after_in_ready", W'(ir), W'(1));
    next();
    drive(0, 1, W'(34'h2AA), 1);
    check("rst_push_ready", W'(ir), W'(1));
    next();
    drive(0, 0, '0, 1);
    wait_single("rst_first", W'(34'h2AA));

`ifdef PIPE_REG_FLUSH_EN
    // flush empties every stage and blocks input that cycle
    for (int k = 0; k < 3; k++) begin
      next();
      drive(0, 1, W'(34'h300 + k), 0);
    end
    next();
    drive(0, 1, W'(34'h3FF), 0);
    flush = 1'b1;
    #1;
    check("flush_in_ready", W'(ir), W'(0));
    next();
    drive(0, 0, '0, 1);
    check("flush_out_valid", W'(ov), W'(0));
    check("flush_after_ready", W'(ir), W'(1));
    next();
    drive(0, 1, W'(34'h155), 1);
    next();
    drive(0, 0, '0, 1);
    wait_single("flush_first", W'(34'h155));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
